// File: rtl/relu_goodness_unit.sv
// relu_goodness_unit: ReLU on the MAC write stream into act_out, plus a saturating sum of squares (goodness) with a threshold decision.
// Latency: act_out[addr] is visible 1 cycle after the write; goodness_valid pulses 4 cycles after in_done.
// Backpressure: none; one write per cycle is accepted, and writes outside a pass are dropped.
module relu_goodness_unit #(
  parameter int NUM_NEURONS = 256,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_start,
  input  logic                                    in_we,
  input  logic [$clog2(NUM_NEURONS)-1:0]          in_addr,
  input  logic [DATA_WIDTH-1:0]                   in_wdata,
  input  logic                                    in_done,
  input  logic [DATA_WIDTH-1:0]                   threshold,
  output logic [0:NUM_NEURONS-1][DATA_WIDTH-1:0]  act_out,
  output logic [DATA_WIDTH-1:0]                   goodness,
  output logic                                    goodness_valid,
  output logic                                    is_positive,
  output logic                                    count_err,
  output logic                                    busy
);

  localparam int AW = $clog2(NUM_NEURONS);
  localparam int CW = AW + 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [CW-1:0]         NUM_N = CW'(NUM_NEURONS);
  localparam logic [DATA_WIDTH-1:0] G_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FINAL} state_t;

  state_t                state, next_state;
  logic                  drain_cnt;
  logic                  accept;
  logic [DATA_WIDTH-1:0] relu;
  logic [DATA_WIDTH-1:0] s1_relu;
  logic                  s1_vld;
  logic [CW-1:0]         count;
  logic [PW-1:0]         acc;
  logic [PW-1:0]         prod;
  logic [PW-1:0]         sq;
  logic [PW:0]           acc_sum;
  logic [DATA_WIDTH-1:0] g_sat;

  // Writes count only inside the pass (ACCUM includes the in_done cycle); in_start aborts, so a coincident write is dropped.
  assign accept  = (state == ACCUM) && in_we && !in_start && ({1'b0, in_addr} < NUM_N);
  assign relu    = in_wdata[DATA_WIDTH-1] ? '0 : in_wdata;
  assign prod    = {{DATA_WIDTH{1'b0}}, s1_relu} * {{DATA_WIDTH{1'b0}}, s1_relu};
  assign sq      = prod >> FRAC_BITS;
  assign acc_sum = {1'b0, acc} + {1'b0, sq};
  assign g_sat   = (acc > {{DATA_WIDTH{1'b0}}, G_MAX}) ? G_MAX : acc[DATA_WIDTH-1:0];
  assign busy    = (state != IDLE);

  // State register and the two-cycle drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= next_state;
      drain_cnt <= (state == DRAIN) && !in_start;
    end
  end

  // Next-state logic; in_start from any state (re)starts a pass.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = IDLE;
      ACCUM:   if (in_done) next_state = DRAIN;
      DRAIN:   if (drain_cnt) next_state = FINAL;
      FINAL:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (in_start) next_state = ACCUM;
  end

  // Stage 1 writes the rectified value to act_out; entries are only overwritten by new writes, never cleared by in_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_out <= '0;
    end else if (accept) begin
      act_out[in_addr] <= relu;
    end
  end

  // Pipeline, saturating accumulator, write counter and the latched results.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_relu        <= '0;
      s1_vld         <= 1'b0;
      count          <= '0;
      acc            <= '0;
      goodness       <= '0;
      goodness_valid <= 1'b0;
      is_positive    <= 1'b0;
      count_err      <= 1'b0;
    end else begin
      goodness_valid <= 1'b0;
      if (in_start) begin
        s1_vld      <= 1'b0;
        count       <= '0;
        acc         <= '0;
        goodness    <= '0;
        is_positive <= 1'b0;
        count_err   <= 1'b0;
      end else begin
        s1_vld <= accept;
        if (accept) begin
          s1_relu <= relu;
          if (count != '1) count <= count + 1'b1;
        end
        if (s1_vld) begin
          acc <= acc_sum[PW] ? '1 : acc_sum[PW-1:0];
        end
        if (state == FINAL) begin
          goodness       <= g_sat;
          is_positive    <= (g_sat > threshold);
          count_err      <= (count != NUM_N);
          goodness_valid <= 1'b1;
        end
      end
    end
  end

endmodule
